// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, frame constants and cycle helpers for the PS/2 host side
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam int unsigned DEF_CLK_FREQ_HZ      = 50_000_000;
    localparam int unsigned DEF_INHIBIT_US       = 100;
    localparam int unsigned DEF_START_TIMEOUT_US = 15000;
    localparam int unsigned DEF_BIT_TIMEOUT_US   = 2000;

    localparam int unsigned REQ_HOLD   = 100;
    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned FRAME_LEN  = 11;

    localparam int unsigned PHASE_W = 13;
    localparam int unsigned TMO_W   = 20;
    localparam int unsigned BIT_W   = 4;

    localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(FRAME_LEN - 2);

    function automatic int unsigned cycles_from_us(input int unsigned freq_hz, input int unsigned us);
        longint unsigned prod;
        prod = (64'(freq_hz) * 64'(us)) / 64'd1_000_000;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - two-flop synchronizer followed by a consecutive-sample deglitch
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned LEN = FILTER_LEN
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic level
);

    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] run;

    // Bring the raw pin into the clock domain; the idle bus level is high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // Adopt the synchronized level only after LEN consecutive samples disagree with the output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            level <= 1'b1;
            run   <= '0;
        end else if (sync_b == level) begin
            run <= '0;
        end else if (run == CNT_LAST) begin
            level <= sync_b;
            run   <= '0;
        end else begin
            run <= run + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-drain enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = DEF_CLK_FREQ_HZ,
    parameter int unsigned INHIBIT_US       = DEF_INHIBIT_US,
    parameter int unsigned START_TIMEOUT_US = DEF_START_TIMEOUT_US,
    parameter int unsigned BIT_TIMEOUT_US   = DEF_BIT_TIMEOUT_US
) (
    input  logic       CLK_50MHZ,
    input  logic       RST_n,
    input  logic [7:0] DIN,
    input  logic       WR,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_OK,
    output logic       ERR,
    input  logic       PS2_CLK_I,
    input  logic       PS2_DATA_I,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam int unsigned INHIBIT_CYC = cycles_from_us(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = cycles_from_us(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned BIT_CYC     = cycles_from_us(CLK_FREQ_HZ, BIT_TIMEOUT_US);

    localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYC - 1);
    localparam logic [PHASE_W-1:0] REQ_LAST     = PHASE_W'(REQ_HOLD - 1);
    localparam logic [TMO_W-1:0]   START_LAST   = TMO_W'(START_CYC - 1);
    localparam logic [TMO_W-1:0]   BIT_LAST     = TMO_W'(BIT_CYC - 1);

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [TMO_W-1:0]   tmo;
    logic [TMO_W-1:0]   tmo_limit;
    logic [BIT_W-1:0]   bit_idx;
    logic [9:0]         tx_bits;
    logic               ack_seen;
    logic               clk_f;
    logic               data_f;
    logic               clk_prev;
    logic               fall;
    logic               timed;
    logic               progress;
    logic               abort;

    ps2_line_filter #(.LEN(FILTER_LEN)) u_clk_filter (
        .clk    (CLK_50MHZ),
        .resetn (RST_n),
        .pin    (PS2_CLK_I),
        .level  (clk_f)
    );

    ps2_line_filter #(.LEN(FILTER_LEN)) u_data_filter (
        .clk    (CLK_50MHZ),
        .resetn (RST_n),
        .pin    (PS2_DATA_I),
        .level  (data_f)
    );

    assign fall = clk_prev & ~clk_f;

    // The first device edge gets the long start budget, every later event the per-bit budget.
    always_comb begin
        tmo_limit = BIT_LAST;
        timed     = 1'b0;
        progress  = fall;
        if (bit_idx == '0) begin
            tmo_limit = START_LAST;
        end
        if ((state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE)) begin
            timed = 1'b1;
        end
        if (state == ST_WAIT_IDLE) begin
            progress = clk_f & data_f;
        end
        abort = timed && !progress && (tmo == tmo_limit);
    end

    // Request-to-send sequencer, bit shifter and handshake outputs.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            phase       <= '0;
            tmo         <= '0;
            bit_idx     <= '0;
            tx_bits     <= '0;
            ack_seen    <= 1'b0;
            clk_prev    <= 1'b1;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ACK_OK      <= 1'b0;
            ERR         <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                BUSY        <= 1'b0;
                ERR         <= 1'b1;
                ACK_OK      <= 1'b0;
                PS2_CLK_OE  <= 1'b0;
                PS2_DATA_OE <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (WR) begin
                            tx_bits     <= {1'b1, ~^DIN, DIN};
                            ACK_OK      <= 1'b0;
                            ack_seen    <= 1'b0;
                            BUSY        <= 1'b1;
                            PS2_CLK_OE  <= 1'b1;
                            PS2_DATA_OE <= 1'b0;
                            phase       <= '0;
                            bit_idx     <= '0;
                            state       <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (phase == INHIBIT_LAST) begin
                            PS2_DATA_OE <= 1'b1;
                            phase       <= '0;
                            state       <= ST_REQ;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (phase == REQ_LAST) begin
                            PS2_CLK_OE <= 1'b0;
                            tmo        <= '0;
                            bit_idx    <= '0;
                            state      <= ST_SEND;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (fall) begin
                            PS2_DATA_OE <= ~tx_bits[0];
                            tx_bits     <= {1'b1, tx_bits[9:1]};
                            bit_idx     <= (bit_idx == '1) ? bit_idx : bit_idx + 1'b1;
                            tmo         <= '0;
                            if (bit_idx == STOP_IDX) begin
                                state <= ST_ACK;
                            end
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (fall) begin
                            ack_seen <= ~data_f;
                            bit_idx  <= (bit_idx == '1) ? bit_idx : bit_idx + 1'b1;
                            tmo      <= '0;
                            state    <= ST_WAIT_IDLE;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_f && data_f) begin
                            DONE   <= 1'b1;
                            BUSY   <= 1'b0;
                            ACK_OK <= ack_seen;
                            state  <= ST_IDLE;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        BUSY        <= 1'b0;
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int unsigned START_CYC = 5000;
    localparam int unsigned BIT_CYC   = 1000;
    localparam int          H         = 200;

    typedef struct {
        bit          is_done;
        bit          ack;
        logic [9:0]  bits;
        int unsigned at_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [7:0]  din;
    logic        busy;
    logic        done;
    logic        ack_ok;
    logic        err;
    logic        clk_oe;
    logic        data_oe;
    logic        dev_clk_low;
    logic        dev_data_low;
    logic        pin_clk;
    logic        pin_data;
    logic [9:0]  dev_bits;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          evt_count = 0;
    exp_t        sb_q[$];

    assign pin_clk  = ~(clk_oe | dev_clk_low);
    assign pin_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ      (50_000_000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (100),
        .BIT_TIMEOUT_US   (20)
    ) dut (
        .CLK_50MHZ   (clk),
        .RST_n       (rst_n),
        .DIN         (din),
        .WR          (wr),
        .BUSY        (busy),
        .DONE        (done),
        .ACK_OK      (ack_ok),
        .ERR         (err),
        .PS2_CLK_I   (pin_clk),
        .PS2_DATA_I  (pin_data),
        .PS2_CLK_OE  (clk_oe),
        .PS2_DATA_OE (data_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Monitor: every DONE/ERR pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done || err)) begin
            evt_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_event", {30'd0, done, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", {30'd0, done, err}, e.is_done ? 32'd2 : 32'd1);
                check("busy_at_event", 32'(busy), 32'd0);
                check("clk_oe_at_event", 32'(clk_oe), 32'd0);
                check("data_oe_at_event", 32'(data_oe), 32'd0);
                check("ack_ok_at_event", 32'(ack_ok), 32'(e.ack));
                if (e.is_done) check("frame_bits", 32'(dev_bits), 32'(e.bits));
                else           check("err_cycle", cyc, e.at_cyc);
            end
        end
    end

    task automatic start_frame(input logic [7:0] b, output int unsigned rel);
        int n;
        din = b;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        check("busy_on_accept", 32'(busy), 32'd1);
        check("clk_oe_on_accept", 32'(clk_oe), 32'd1);
        check("data_oe_on_accept", 32'(data_oe), 32'd0);
        check("ack_ok_cleared", 32'(ack_ok), 32'd0);
        n = 0;
        while (!data_oe && n < 6000) begin
            tick();
            n++;
            if (n == 40) begin
                din = 8'h00;
                wr  = 1'b1;
            end
            if (n == 41) wr = 1'b0;
        end
        check("data_oe_rise_cycles", n, 32'd5000);
        while (clk_oe && n < 6000) begin
            tick();
            n++;
        end
        check("clk_oe_low_cycles", n, 32'd5100);
        check("start_bit_held", 32'(data_oe), 32'd1);
        rel = cyc;
    endtask

    task automatic device_frame(input int nclk, input bit ack, input bit disturb, input bit meas,
                                output int unsigned last_fall);
        int lat;
        dev_bits = '0;
        last_fall = 0;
        check("start_bit_on_pin", 32'(pin_data), 32'd0);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) begin
                ticks(H / 2);
                dev_data_low = 1'b1;
                ticks(H / 2);
            end else begin
                ticks(H);
            end
            if (disturb && k == 5) begin
                din = 8'h00;
                wr  = 1'b1;
                tick();
                wr  = 1'b0;
            end
            dev_clk_low = 1'b1;
            last_fall = cyc;
            lat = 0;
            for (int i = 1; i <= H; i++) begin
                tick();
                if (meas && k == 1 && lat == 0 && !data_oe) lat = i;
            end
            if (meas && k == 1) check("edge_to_data_oe", lat, 32'd11);
            if (k <= 10) dev_bits[k-1] = pin_data;
            dev_clk_low = 1'b0;
            if (disturb && k == 3) begin
                ticks(50);
                dev_clk_low = 1'b1;
                ticks(5);
                dev_clk_low = 1'b0;
            end
        end
        ticks(5);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_evt(input string name, input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            tick();
            if (done || err) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        int unsigned r;
        int unsigned lf;
        int          ev0;
        rst_n = 1'b0;
        wr = 1'b0;
        din = 8'h00;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        dev_bits = '0;
        ticks(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_ack_ok", 32'(ack_ok), 32'd0);
        check("reset_clk_oe", 32'(clk_oe), 32'd0);
        check("reset_data_oe", 32'(data_oe), 32'd0);
        rst_n = 1'b1;
        ticks(20);

        // 0xED with ACK, glitch on the clock and WR pulses while busy
        sb_q.push_back('{is_done: 1'b1, ack: 1'b1, bits: 10'h3ED, at_cyc: 0});
        start_frame(8'hED, r);
        device_frame(11, 1'b1, 1'b1, 1'b1, lf);
        wait_evt("done_ed", 2000);
        ticks(5);
        check("ack_ok_held", 32'(ack_ok), 32'd1);

        // 0x07 with NACK, then a new WR on the cycle after DONE
        sb_q.push_back('{is_done: 1'b1, ack: 1'b0, bits: 10'h207, at_cyc: 0});
        start_frame(8'h07, r);
        device_frame(11, 1'b0, 1'b0, 1'b0, lf);
        wait_evt("done_07", 2000);

        // Device never clocks
        start_frame(8'h3C, r);
        sb_q.push_back('{is_done: 1'b0, ack: 1'b0, bits: 10'h000, at_cyc: r + START_CYC});
        wait_evt("err_start", START_CYC + 100);
        ticks(20);

        // Device stops after four clocks
        start_frame(8'h55, r);
        device_frame(4, 1'b0, 1'b0, 1'b0, lf);
        sb_q.push_back('{is_done: 1'b0, ack: 1'b0, bits: 10'h000, at_cyc: lf + 11 + BIT_CYC});
        wait_evt("err_bit", BIT_CYC + 100);
        ticks(20);

        // Reset while bit 3 of 0xA5 is on the bus
        ev0 = evt_count;
        start_frame(8'hA5, r);
        device_frame(3, 1'b0, 1'b0, 1'b0, lf);
        ticks(H);
        dev_clk_low = 1'b1;
        ticks(30);
        check("bit3_driven", 32'(data_oe), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_clk_oe", 32'(clk_oe), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        dev_clk_low = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(20);
        check("no_event_on_reset", evt_count, ev0);

        sb_q.push_back('{is_done: 1'b1, ack: 1'b1, bits: 10'h2F4, at_cyc: 0});
        start_frame(8'hF4, r);
        device_frame(11, 1'b1, 1'b0, 1'b0, lf);
        wait_evt("done_f4", 2000);
        ticks(10);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
